// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a prod_last-terminated run of unsigned 64-bit
// products into an ACC_W-bit accumulator and presents sum, term count and
// a sticky overflow flag over a valid/ready handshake.
// Optional feature macro: MAC_ACC_SAT_EN -- when defined, the accumulator
// saturates to all ones on overflow instead of wrapping.
module mac_accumulator #(
  parameter int ACC_W = 80,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      prod,
  input  logic             prod_valid,
  input  logic             prod_last,
  output logic             prod_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] acc_count,
  output logic             ovf,
  output logic             acc_valid,
  input  logic             acc_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] count_next;
  logic             ovf_next;
  logic             valid_next;
  logic             beat;
  logic [ACC_W:0]   prod_ext;
  logic [ACC_W:0]   sum;

  // Ready depends only on state and clear so there is no valid-to-ready path.
  assign prod_ready = (state != DONE) && !clear;
  assign beat       = prod_valid && prod_ready;

  // One guard bit above the accumulator catches the carry out of the top bit.
  assign prod_ext = {{(ACC_W + 1 - 64){1'b0}}, prod};
  assign sum      = {1'b0, acc} + prod_ext;

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-datapath decode; clear overrides everything else.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = acc_count;
    ovf_next   = ovf;
    if (clear) begin
      state_next = IDLE;
      acc_next   = '0;
      count_next = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (beat) begin
            acc_next   = prod_ext[ACC_W-1:0];
            count_next = CNT_W'(1);
            ovf_next   = 1'b0;
            state_next = prod_last ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
`ifdef MAC_ACC_SAT_EN
            if (sum[ACC_W] || ovf) begin
              acc_next = '1;
            end else begin
              acc_next = sum[ACC_W-1:0];
            end
`else
            acc_next = sum[ACC_W-1:0];
`endif
            ovf_next = ovf | sum[ACC_W];
            if (acc_count != '1) begin
              count_next = acc_count + CNT_W'(1);
            end
            if (prod_last) begin
              state_next = DONE;
            end
          end
        end
        DONE: begin
          if (acc_ready) begin
            state_next = IDLE;
            acc_next   = '0;
            count_next = '0;
            ovf_next   = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
        end
      endcase
    end
  end

  assign valid_next = (state_next == DONE);

  // Result registers, including a registered valid that rises one cycle after the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      acc_count <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      acc       <= acc_next;
      acc_count <= count_next;
      ovf       <= ovf_next;
      acc_valid <= valid_next;
    end
  end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Accumulation stage of the 32-bit MAC unit. It sits directly downstream of the 32x32 multiplier and consumes its unsigned 64-bit product stream over a valid/ready handshake. It sums a run of products terminated by a `prod_last` marker into a wide accumulator with guard bits. It then presents the registered sum, the term count and an overflow flag to the consumer over a second valid/ready handshake.

## Interface
- `ACC_W`, default 80: accumulator width in bits, minimum 64. Products are zero-extended to this width.
- `CNT_W`, default 16: width of the term counter.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `prod`  in  64  unsigned product from the multiplier.
- `prod_valid`  in  1  `prod` and `prod_last` are valid.
- `prod_last`  in  1  the current beat is the final term of the run.
- `prod_ready`  out  1  the block accepts a beat this cycle.
- `clear`  in  1  synchronous abort/clear of the current run.
- `acc`  out  ACC_W  accumulated sum.
- `acc_count`  out  CNT_W  number of terms accepted in the run.
- `ovf`  out  1  sticky overflow flag for the run.
- `acc_valid`  out  1  result is valid.
- `acc_ready`  in  1  consumer takes the result.

## Operation
- **States:**
  - IDLE: accumulator is 0, no term accepted yet.
  - ACCUM: one or more terms accepted.
  - DONE: result presented.
- **Beat acceptance:** a beat is accepted when `prod_valid && prod_ready`.
- **Accept in IDLE:** `acc <= prod` (zero-extended), `acc_count <= 1`, `ovf <= 0`. Next state is ACCUM, or DONE if `prod_last`.
- **Accept in ACCUM:** `acc <= acc + prod`, computed ACC_W+1 bits wide. A carry out of bit ACC_W-1 sets `ovf`, which stays set until the run ends. `acc_count` increments and saturates at 2^CNT_W-1. If `prod_last`, next state is DONE; otherwise the state stays ACCUM.
- **Gaps:** gaps in `prod_valid` are allowed in any state; state and accumulator hold.
- **DONE:**
  - `acc_valid = 1`.
  - `acc`, `acc_count` and `ovf` are held stable while `acc_ready` is low.
  - On `acc_ready`: `acc`, `acc_count` and `ovf` clear to 0 and the next state is IDLE.
- **`clear`:** highest priority, effective in every state.
  - Next cycle: state IDLE, `acc = 0`, `acc_count = 0`, `ovf = 0`, `acc_valid = 0`.
  - A beat presented in the same cycle is not accepted, because `prod_ready` is low.
  - A pending result in DONE is discarded.
- **Reset:** `rst` high forces state IDLE and all outputs to 0 (`prod_ready` to 1) immediately, independent of `clk`, including mid-run.

## Timing
- `prod_ready = (state != DONE) && !clear`. It is combinational from state and `clear` only, with no path from `prod_valid`.
- `acc_valid` is registered. It rises on the cycle after the `prod_last` beat is accepted, so last-beat-to-result latency is 1 cycle.
- Full throughput in ACCUM is one beat per cycle.
- After the result handshake there is exactly one cycle in IDLE (`acc_valid = 0`, `prod_ready = 1`). A beat may be accepted in that cycle.
- No beat is accepted in DONE, so back-to-back runs cost at least one dead input cycle per run.
- A `prod_last` beat accepted in IDLE produces a one-term result with `acc_count = 1`.
- Reset values:
  - `acc = 0`, `acc_count = 0`, `ovf = 0`, `acc_valid = 0`.
  - `prod_ready = 1` while `clear` is low.

## Configuration
- `MAC_ACC_SAT_EN` defined: on overflow, `acc` saturates to all ones and holds there for the rest of the run. `ovf` sets as normal.
- Not defined: `acc` wraps modulo 2^ACC_W and `ovf` still sets.
- `acc_count` saturation is unconditional and independent of this macro.

## Test plan
- **Basic run:** beats 2, 3, 5 on consecutive cycles, last on 5, `acc_ready = 1` → one cycle later `acc_valid = 1`, `acc = 10`, `acc_count = 3`, `ovf = 0`. Next cycle `acc_valid = 0`, `acc = 0`.
- **Single term with gaps:** beat 64'hFFFF_FFFF_FFFF_FFFF with `prod_last = 1` after 3 idle cycles → `acc` = 80'h0000_FFFF_FFFF_FFFF_FFFF, `acc_count = 1`.
- **Backpressure:**
  - Setup: run 4, 6, last on 6, with `acc_ready` low for 4 cycles and `prod_valid` held high with 9.
  - Required during stall: `acc = 10` stable and `prod_ready = 0` throughout.
  - Required on release: after `acc_ready` rises, 9 is accepted in the IDLE cycle as a new run.
- **Overflow (`ACC_W = 64`):** beats 2^64-1, then 2 with last → `ovf = 1`. Without the macro `acc = 1`; with `MAC_ACC_SAT_EN` `acc` = 64'hFFFF_FFFF_FFFF_FFFF.
- **Clear mid-run:**
  - Setup: after beats 5 and 6, pulse `clear` with `prod_valid` high and `prod` = 100. Then send beat 7 with last.
  - Required: the 100 beat is not accepted, and the result is `acc = 7`, `acc_count = 1`.
- **Async reset:** assert `rst` between clock edges during ACCUM with `acc = 20` → all outputs 0 before the next edge. After release, beat 3 with last gives `acc = 3`.
